// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared definitions for the EX-stage ALU with multiply/divide.
//   - 5-bit ALU op encodings used on op_i
//   - state encoding of the iterative multiply/divide engine
//   - is_md_op():    op reads or writes HI/LO (stalls while the engine is busy)
//   - is_start_op(): op launches a multiply or divide
package alu_md_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_LUI   = 5'd6;
  localparam logic [4:0] OP_SLT   = 5'd7;
  localparam logic [4:0] OP_SLTU  = 5'd8;
  localparam logic [4:0] OP_SLL   = 5'd9;
  localparam logic [4:0] OP_SRL   = 5'd10;
  localparam logic [4:0] OP_SRA   = 5'd11;
  localparam logic [4:0] OP_SLLV  = 5'd12;
  localparam logic [4:0] OP_SRLV  = 5'd13;
  localparam logic [4:0] OP_SRAV  = 5'd14;
  localparam logic [4:0] OP_MULT  = 5'd15;
  localparam logic [4:0] OP_MULTU = 5'd16;
  localparam logic [4:0] OP_DIV   = 5'd17;
  localparam logic [4:0] OP_DIVU  = 5'd18;
  localparam logic [4:0] OP_MFHI  = 5'd19;
  localparam logic [4:0] OP_MFLO  = 5'd20;
  localparam logic [4:0] OP_MTHI  = 5'd21;
  localparam logic [4:0] OP_MTLO  = 5'd22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_t;

  function automatic logic is_md_op(input logic [4:0] op);
    return (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                       OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO});
  endfunction

  function automatic logic is_start_op(input logic [4:0] op);
    return (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
  endfunction

endpackage

// File: rtl/alu_md_md_iter.sv
// md_iter: radix-2 iterative multiply/divide engine, one bit per cycle.
// Signed operations run on operand magnitudes; the sign fix-up is applied
// combinationally in the final cycle so the top can write HI/LO at that edge.
// Ports:
//   clk, rst       clock, synchronous active-high reset (aborts a running op)
//   start_i        launch an operation (only honoured in IDLE)
//   div_i          1 = divide, 0 = multiply
//   sgn_i          1 = signed operands
//   a_i, b_i       multiplicand/dividend and multiplier/divisor
//   busy_o         engine not IDLE (registered)
//   done_o         last iteration in progress; hi_o/lo_o are final this cycle
//   hi_o, lo_o     result, valid only while done_o is high
module md_iter
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             sgn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_t        state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  // x: partial product upper half / remainder; y: multiplier / dividend->quotient
  logic [WIDTH-1:0] x_reg, x_next, y_reg, y_next;
  logic [WIDTH-1:0] m_reg, m_next;   // multiplicand / divisor magnitude
  logic [WIDTH-1:0] a_reg, a_next;   // raw dividend, returned as HI on divide by zero
  logic             neg_hi_reg, neg_hi_next, neg_lo_reg, neg_lo_next;
  logic             dz_reg, dz_next;

  logic [WIDTH:0]     mul_sum, div_trial;
  logic [WIDTH-1:0]   step_x, step_y, a_abs, b_abs;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // One iteration of the current algorithm applied to the registered state.
  always_comb begin
    mul_sum   = {1'b0, x_reg} + {1'b0, (y_reg[0] ? m_reg : '0)};
    // Restoring divide: trial subtract of the shifted remainder; MSB set means borrow.
    div_trial = {x_reg, y_reg[WIDTH-1]} - {1'b0, m_reg};
    step_x    = x_reg;
    step_y    = y_reg;
    if (state_reg == ST_MUL) begin
      step_x = mul_sum[WIDTH:1];
      step_y = {mul_sum[0], y_reg[WIDTH-1:1]};
    end else if (state_reg == ST_DIV) begin
      if (!div_trial[WIDTH]) begin
        step_x = div_trial[WIDTH-1:0];
        step_y = {y_reg[WIDTH-2:0], 1'b1};
      end else begin
        step_x = {x_reg[WIDTH-2:0], y_reg[WIDTH-1]};
        step_y = {y_reg[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Final result with sign correction, taken from this cycle's last step.
  always_comb begin
    prod     = {step_x, step_y};
    prod_fix = neg_lo_reg ? -prod : prod;
    if (state_reg == ST_MUL) begin
      hi_o = prod_fix[2*WIDTH-1:WIDTH];
      lo_o = prod_fix[WIDTH-1:0];
    end else begin
      // Divide by zero bypasses the datapath: LO all ones, HI the dividend.
      lo_o = dz_reg ? '1    : (neg_lo_reg ? -step_y : step_y);
      hi_o = dz_reg ? a_reg : (neg_hi_reg ? -step_x : step_x);
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    m_next      = m_reg;
    a_next      = a_reg;
    neg_hi_next = neg_hi_reg;
    neg_lo_next = neg_lo_reg;
    dz_next     = dz_reg;
    a_abs       = (sgn_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_abs       = (sgn_i && b_i[WIDTH-1]) ? -b_i : b_i;
    case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          state_next  = div_i ? ST_DIV : ST_MUL;
          cnt_next    = CW'(WIDTH);
          x_next      = '0;
          y_next      = a_abs;
          m_next      = b_abs;
          a_next      = a_i;
          // Quotient/product negative when signs differ; remainder follows the dividend.
          neg_lo_next = sgn_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          neg_hi_next = div_i ? (sgn_i & a_i[WIDTH-1])
                              : (sgn_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]));
          dz_next     = div_i & (b_i == '0);
        end
      end
      ST_MUL, ST_DIV: begin
        x_next   = step_x;
        y_next   = step_y;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      m_reg      <= '0;
      a_reg      <= '0;
      neg_hi_reg <= 1'b0;
      neg_lo_reg <= 1'b0;
      dz_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      m_reg      <= m_next;
      a_reg      <= a_next;
      neg_hi_reg <= neg_hi_next;
      neg_lo_reg <= neg_lo_next;
      dz_reg     <= dz_next;
    end
  end

  assign busy_o = (state_reg != ST_IDLE);
  assign done_o = (state_reg != ST_IDLE) && (cnt_reg == CW'(1));

endmodule

// File: rtl/alu_md.sv
// alu_md: EX-stage integer ALU with HI/LO registers and a sequential
// multiply/divide unit that stalls the pipeline while busy.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   a_i, b_i      forwarded operands (rs, rt/immediate); shifts act on b_i
//   shamt_i       instruction shift amount
//   op_i          ALU op (alu_md_pkg encodings)
//   valid_i       instruction is live; gates every HI/LO/FSM side effect
//   result_o      combinational result, zero_o = (result_o == 0)
//   stall_o       HI/LO-touching op presented while the engine is busy
//   busy_o        multiply/divide engine running (registered)
//   hi_o, lo_o    architectural HI/LO
// Build option: define ALU_MD_FAST_MUL_EN for single-cycle MULT/MULTU
// through a full-width multiplier; divides stay iterative.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic [4:0]       op_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0]   hi_reg, hi_next, lo_reg, lo_next;
  logic [WIDTH-1:0]   result, md_hi, md_lo;
  logic [SHW-1:0]     sh_amt;
  logic               md_busy, md_done, md_start, idle_go, md_sgn, md_div;
  logic               fast_we;
  logic [2*WIDTH-1:0] fast_prod;

  // Combinational datapath.
  always_comb begin
    sh_amt = shamt_i;
    if (op_i inside {OP_SLLV, OP_SRLV, OP_SRAV}) begin
      sh_amt = a_i[SHW-1:0];
    end
    result = '0;
    case (op_i)
      OP_ADD:           result = a_i + b_i;
      OP_SUB:           result = a_i - b_i;
      OP_AND:           result = a_i & b_i;
      OP_OR:            result = a_i | b_i;
      OP_XOR:           result = a_i ^ b_i;
      OP_NOR:           result = ~(a_i | b_i);
      OP_LUI:           result = {b_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLT:           result = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU:          result = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      OP_SLL, OP_SLLV:  result = b_i << sh_amt;
      OP_SRL, OP_SRLV:  result = b_i >> sh_amt;
      OP_SRA, OP_SRAV:  result = $signed(b_i) >>> sh_amt;
      OP_MFHI:          result = hi_reg;
      OP_MFLO:          result = lo_reg;
      default:          result = '0;
    endcase
  end

  assign result_o = result;
  assign zero_o   = (result == '0);

  // A live HI/LO op proceeds only when the engine is idle; otherwise it stalls
  // and the pipeline re-presents it.
  assign idle_go = valid_i & ~md_busy;
  assign stall_o = valid_i & md_busy & is_md_op(op_i);
  assign busy_o  = md_busy;
  assign md_sgn  = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign md_div  = (op_i == OP_DIV) || (op_i == OP_DIVU);

`ifdef ALU_MD_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_a, fast_b;
  always_comb begin
    // Sign/zero extension to 2*WIDTH makes one unsigned multiply serve both.
    fast_a    = {{WIDTH{md_sgn & a_i[WIDTH-1]}}, a_i};
    fast_b    = {{WIDTH{md_sgn & b_i[WIDTH-1]}}, b_i};
    fast_prod = fast_a * fast_b;
  end
  assign fast_we  = idle_go & ((op_i == OP_MULT) || (op_i == OP_MULTU));
  assign md_start = idle_go & md_div;
`else
  assign fast_prod = '0;
  assign fast_we   = 1'b0;
  assign md_start  = idle_go & is_start_op(op_i);
`endif

  md_iter #(
    .WIDTH (WIDTH)
  ) u_md_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_start),
    .div_i   (md_div),
    .sgn_i   (md_sgn),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (md_busy),
    .done_o  (md_done),
    .hi_o    (md_hi),
    .lo_o    (md_lo)
  );

  // md_done only occurs while busy, so it never collides with an idle MT/fast op.
  always_comb begin
    hi_next = hi_reg;
    lo_next = lo_reg;
    if (md_done) begin
      hi_next = md_hi;
      lo_next = md_lo;
    end else if (fast_we) begin
      hi_next = fast_prod[2*WIDTH-1:WIDTH];
      lo_next = fast_prod[WIDTH-1:0];
    end else if (idle_go && (op_i == OP_MTHI)) begin
      hi_next = a_i;
    end else if (idle_go && (op_i == OP_MTLO)) begin
      lo_next = a_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      hi_reg <= hi_next;
      lo_reg <= lo_next;
    end
  end

  assign hi_o = hi_reg;
  assign lo_o = lo_reg;

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md (WIDTH=32). Stimulus pushes expected
// observations tagged with the cycle they are due; a negedge monitor pops and
// compares them. Expected values come from directed constants or from a
// plain-arithmetic reference model (64-bit multiply, native / and %).
module tb_alu_md;
  import alu_md_pkg::*;

  localparam int W   = 32;
  localparam int SHW = 5;
`ifdef ALU_MD_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   a_i, b_i;
  logic [SHW-1:0] shamt_i;
  logic [4:0]     op_i;
  logic           valid_i;
  logic [W-1:0]   result_o, hi_o, lo_o;
  logic           zero_o, stall_o, busy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W-1:0] m_hi, m_lo;

  alu_md #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_i      (a_i),
    .b_i      (b_i),
    .shamt_i  (shamt_i),
    .op_i     (op_i),
    .valid_i  (valid_i),
    .result_o (result_o),
    .zero_o   (zero_o),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       due;
    string    name;
    bit       cr;  logic [W-1:0] res;
    bit       cz;  bit zero;
    bit       ch;  logic [W-1:0] hi; logic [W-1:0] lo;
    bit       cb;  bit busy;
    bit       cs;  bit stall;
    bit       last;
  } exp_t;

  exp_t sbq[$];

  function automatic exp_t mk(input int due, input string name);
    exp_t e;
    e.due = due; e.name = name;
    e.cr = 0; e.res = '0; e.cz = 0; e.zero = 0; e.ch = 0; e.hi = '0; e.lo = '0;
    e.cb = 0; e.busy = 0; e.cs = 0; e.stall = 0; e.last = 0;
    return e;
  endfunction

  task automatic cmp(input string n, input string f, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s cycle %0d: got %h want %h", n, f, cyc, act, req);
    end
  endtask

  task automatic check_entry(input exp_t e);
    if (e.cr) cmp(e.name, "result", result_o, e.res);
    if (e.cz) cmp(e.name, "zero", W'(zero_o), W'(e.zero));
    if (e.ch) begin
      cmp(e.name, "hi", hi_o, e.hi);
      cmp(e.name, "lo", lo_o, e.lo);
    end
    if (e.cb) cmp(e.name, "busy", W'(busy_o), W'(e.busy));
    if (e.cs) cmp(e.name, "stall", W'(stall_o), W'(e.stall));
    if (e.last) $display("txn %s cycle %0d result=%h hi=%h lo=%h", e.name, cyc, result_o, hi_o, lo_o);
  endtask

  // Monitor: pop every expectation due this cycle.
  int mon_k;
  always @(negedge clk) begin
    mon_k = 0;
    while (mon_k < sbq.size()) begin
      if (sbq[mon_k].due <= cyc) begin
        if (sbq[mon_k].due < cyc) begin
          total++; bad++;
          $display("FAIL %s.stale due %0d seen at cycle %0d", sbq[mon_k].name, sbq[mon_k].due, cyc);
        end else begin
          check_entry(sbq[mon_k]);
        end
        sbq.delete(mon_k);
      end else begin
        mon_k++;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_comb(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [SHW-1:0] sh, input logic [W-1:0] h, input logic [W-1:0] l);
    logic [W-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_LUI:  r = (b & 32'h0000_FFFF) << 16;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  r = b << sh;
      OP_SRL:  r = b >> sh;
      OP_SRA:  r = $signed(b) >>> sh;
      OP_SLLV: r = b << (a % W);
      OP_SRLV: r = b >> (a % W);
      OP_SRAV: r = $signed(b) >>> (a % W);
      OP_MFHI: r = h;
      OP_MFLO: r = l;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic ref_md(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] h, output logic [W-1:0] l);
    longint sa, sb, p, q, r;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0; l = '0;
    if (op == OP_MULT) begin
      p = sa * sb; h = p[63:32]; l = p[31:0];
    end else if (op == OP_MULTU) begin
      up = 64'(a) * 64'(b); h = up[63:32]; l = up[31:0];
    end else if (b == '0) begin
      h = a; l = '1;
    end else if (op == OP_DIV) begin
      q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0];
    end else begin
      h = a % b; l = a / b;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SHW-1:0] sh, input logic v);
    op_i = op; a_i = a; b_i = b; shamt_i = sh; valid_i = v;
  endtask

  task automatic bubble();
    drive(OP_ADD, '0, '0, '0, 1'b0);
  endtask

  task automatic comb_chk(input string name, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [SHW-1:0] sh, input logic v, input logic [W-1:0] exp_r);
    exp_t e;
    drive(op, a, b, sh, v);
    e = mk(cyc, name);
    e.cr = 1; e.res = exp_r; e.cz = 1; e.zero = (exp_r == '0);
    e.ch = 1; e.hi = m_hi; e.lo = m_lo;
    e.cb = 1; e.busy = 0; e.cs = 1; e.stall = 0; e.last = 1;
    sbq.push_back(e);
    tick();
  endtask

  task automatic md_issue(input string name, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_h, input logic [W-1:0] exp_l);
    exp_t e;
    int t, lat;
    drive(op, a, b, '0, 1'b1);
    t = cyc;
    lat = (FAST && (op == OP_MULT || op == OP_MULTU)) ? 1 : W + 1;
    e = mk(t, {name, "_issue"}); e.cs = 1; e.stall = 0; e.cb = 1; e.busy = 0; e.cr = 1; e.res = '0;
    sbq.push_back(e);
    for (int k = 1; k < lat; k++) begin
      e = mk(t + k, {name, "_busy"}); e.cb = 1; e.busy = 1;
      sbq.push_back(e);
    end
    e = mk(t + lat, name); e.ch = 1; e.hi = exp_h; e.lo = exp_l; e.cb = 1; e.busy = 0; e.last = 1;
    sbq.push_back(e);
    tick();
    bubble();
    repeat (lat - 1) tick();
    m_hi = exp_h; m_lo = exp_l;
  endtask

  task automatic mt_chk(input string name, input logic [4:0] op, input logic [W-1:0] a);
    exp_t e;
    drive(op, a, '0, '0, 1'b1);
    if (op == OP_MTHI) m_hi = a; else m_lo = a;
    e = mk(cyc + 1, name); e.ch = 1; e.hi = m_hi; e.lo = m_lo; e.last = 1;
    sbq.push_back(e);
    tick();
    bubble();
  endtask

  task automatic rand_comb(input int n);
    logic [4:0] op; logic [W-1:0] a, b; logic [SHW-1:0] sh; logic v;
    for (int k = 0; k < n; k++) begin
      op = 5'($urandom_range(0, 31));
      a  = $urandom; b = $urandom;
      sh = SHW'($urandom_range(0, W - 1));
      v  = 1'($urandom_range(0, 1));
      if (is_md_op(op) && op != OP_MFHI && op != OP_MFLO) v = 1'b0;
      comb_chk("rand_comb", op, a, b, sh, v, ref_comb(op, a, b, sh, m_hi, m_lo));
    end
  endtask

  task automatic rand_md(input int n);
    logic [4:0] op; logic [W-1:0] a, b, h, l; int mode;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 3))
        0:       op = OP_MULT;
        1:       op = OP_MULTU;
        2:       op = OP_DIV;
        default: op = OP_DIVU;
      endcase
      a = $urandom;
      mode = $urandom_range(0, 5);
      if (mode == 0)      b = '0;
      else if (mode < 3)  b = ($urandom_range(0, 1) != 0) ? -W'($urandom_range(1, 20)) : W'($urandom_range(1, 20));
      else                b = $urandom;
      ref_md(op, a, b, h, l);
      md_issue("rand_md", op, a, b, h, l);
      rand_comb(2);
    end
  endtask

  task automatic stall_test();
    exp_t e;
    int t;
    drive(OP_DIV, 32'd100, 32'd7, '0, 1'b1);
    t = cyc;
    for (int k = 1; k <= W; k++) begin
      e = mk(t + k, "stall_div_busy"); e.cb = 1; e.busy = 1;
      sbq.push_back(e);
    end
    tick(); bubble(); tick(); tick();
    drive(OP_MTHI, 32'h0000_DEAD, '0, '0, 1'b1);
    e = mk(cyc, "mthi_while_busy"); e.cs = 1; e.stall = 1; e.cr = 1; e.res = '0; e.last = 1;
    sbq.push_back(e);
    tick(); bubble(); tick();
    drive(OP_MFLO, '0, '0, '0, 1'b1);
    for (int k = 5; k <= W; k++) begin
      e = mk(t + k, "mflo_stall"); e.cs = 1; e.stall = 1;
      sbq.push_back(e);
    end
    e = mk(t + W + 1, "mflo_after_div");
    e.cs = 1; e.stall = 0; e.cr = 1; e.res = 32'd14; e.ch = 1; e.hi = 32'd2; e.lo = 32'd14;
    e.cb = 1; e.busy = 0; e.last = 1;
    sbq.push_back(e);
    repeat (W - 4) tick();
    tick();
    bubble();
    m_hi = 32'd2; m_lo = 32'd14;
  endtask

  task automatic reset_test();
    exp_t e;
    int t;
    drive(OP_MULTU, 32'hFFFF_1234, 32'h55, '0, 1'b1);
    t = cyc;
    e = mk(t + 1, "rst_mul_busy");  e.cb = 1; e.busy = 1; sbq.push_back(e);
    e = mk(t + 10, "rst_mul_busy"); e.cb = 1; e.busy = 1; sbq.push_back(e);
    tick(); bubble();
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    e = mk(cyc, "rst_abort"); e.cb = 1; e.busy = 0; e.ch = 1; e.hi = '0; e.lo = '0; e.last = 1;
    sbq.push_back(e);
    tick();
    md_issue("multu_after_rst", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bubble();
    m_hi = '0; m_lo = '0;
    repeat (3) tick();
    rst = 1'b0;

    comb_chk("reset_state",  OP_ADD,  32'd0,         32'd0,         5'd0,  1'b1, 32'd0);
    comb_chk("add_ovf",      OP_ADD,  32'h7FFF_FFFF, 32'd1,         5'd0,  1'b1, 32'h8000_0000);
    comb_chk("sub_zero",     OP_SUB,  32'd5,         32'd5,         5'd0,  1'b1, 32'd0);
    comb_chk("slt_neg",      OP_SLT,  32'hFFFF_FFFF, 32'd1,         5'd0,  1'b1, 32'd1);
    comb_chk("sltu_same",    OP_SLTU, 32'hFFFF_FFFF, 32'd1,         5'd0,  1'b1, 32'd0);
    comb_chk("srav_mod",     OP_SRAV, 32'h24,        32'h8000_0000, 5'd0,  1'b1, 32'hF800_0000);
    comb_chk("lui",          OP_LUI,  32'd0,         32'h1234_ABCD, 5'd0,  1'b1, 32'hABCD_0000);
    comb_chk("nor",          OP_NOR,  32'h0F0F_0000, 32'h0000_00F0, 5'd0,  1'b1, 32'hF0F0_FF0F);
    comb_chk("sll31",        OP_SLL,  32'd0,         32'd1,         5'd31, 1'b1, 32'h8000_0000);
    comb_chk("srl31",        OP_SRL,  32'd0,         32'h8000_0000, 5'd31, 1'b1, 32'd1);
    comb_chk("sra4",         OP_SRA,  32'd0,         32'h8000_0010, 5'd4,  1'b1, 32'hF800_0001);
    comb_chk("undef_op",     5'd31,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  1'b1, 32'd0);
    rand_comb(30);

    md_issue("mult_m2x3",   OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA);
    md_issue("div_m7_2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md_issue("divu_7_0",    OP_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF);
    md_issue("div_min_m1",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    md_issue("div_m7_0",    OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
    md_issue("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);
    md_issue("div_after",   OP_DIV,   32'd100,       32'hFFFF_FFFD, 32'd1,         32'hFFFF_FFDF);
    rand_comb(6);

    stall_test();
    mt_chk("mthi_idle", OP_MTHI, 32'h1234_5678);
    mt_chk("mtlo_idle", OP_MTLO, 32'h9ABC_DEF0);
    comb_chk("mfhi", OP_MFHI, '0, '0, '0, 1'b1, 32'h1234_5678);
    comb_chk("nv_mult", OP_MULT, 32'd5, 32'd6, '0, 1'b0, 32'd0);
    comb_chk("nv_mthi", OP_MTHI, 32'hAAAA_5555, '0, '0, 1'b0, 32'd0);
    comb_chk("nv_after", OP_ADD, 32'd1, 32'd1, '0, 1'b0, 32'd2);

    reset_test();
    rand_comb(4);
    rand_md(10);

    for (int k = 0; k < 200 && sbq.size() > 0; k++) tick();
    if (sbq.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d expectations never checked", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised successor to the EX-stage ALU.
- Same combinational integer datapath, generalised to WIDTH bits, plus SLTU/NOR.
- Adds a sequential multiply/divide unit with architectural HI/LO registers and a stall handshake to the pipeline hazard logic.
- Sits in EX: operands come after forwarding muxes; result_o feeds EX/MEM; stall_o goes to the hazard unit.

Parameters:
- WIDTH, 32, datapath width; must be a power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- a_i  in  WIDTH  operand 1 (rs)
- b_i  in  WIDTH  operand 2 (rt or extended immediate)
- shamt_i  in  SHW  instruction shift amount
- op_i  in  5  ALU op, encoding from package
- valid_i  in  1  EX instruction is live (not bubble/flushed); qualifies all HI/LO-touching ops
- result_o  out  WIDTH  combinational result
- zero_o  out  1  result_o == 0
- stall_o  out  1  combinational: valid_i & busy_o & op_i is an MD/MF/MT op
- busy_o  out  1  registered: MD FSM not IDLE
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: HI=0, LO=0, FSM=IDLE, busy_o=0, iteration counter=0.
- Reset mid-operation aborts the operation; no partial HI/LO write.
- Combinational ops:
  - ADD, SUB, AND, OR, XOR, NOR: modulo 2^WIDTH.
  - LUI: b_i[WIDTH/2-1:0] placed in the upper half, lower half zero.
  - SLT: signed compare; SLTU: unsigned compare.
  - SLL/SRL/SRA: shift by shamt_i. SLLV/SRLV/SRAV: shift by a_i[SHW-1:0].
  - MFHI/MFLO: result_o = hi_o/lo_o.
  - MULT/MULTU/DIV/DIVU/MTHI/MTLO: result_o = 0.
  - Undefined op: result_o = 0, never X.
- MD start: in cycle t, valid_i=1, op in {MULT,MULTU,DIV,DIVU}, FSM=IDLE.
  - Operands latched; FSM -> MUL or DIV; counter=WIDTH.
  - busy_o is high in cycles t+1..t+WIDTH.
  - HI/LO are written at the edge ending cycle t+WIDTH; FSM -> IDLE; new values visible in t+WIDTH+1.
  - A back-to-back start is allowed in cycle t+WIDTH+1.
- Algorithms: radix-2 iterative, one bit per cycle.
  - Signed ops run on magnitudes; sign correction is applied in the final write.
  - Multiply: {HI,LO} = 2*WIDTH-bit product.
  - Divide: LO = quotient truncated toward zero; HI = remainder, sign of dividend.
  - Divide by zero: LO = all ones, HI = a_i; same latency, no exception.
  - Signed MIN / -1: LO = MIN, HI = 0.
- MTHI/MTLO with valid_i and FSM IDLE: HI/LO = a_i at the clock edge.
- Any MD/MF/MT op while busy_o=1:
  - stall_o=1, the op is ignored, and state is unchanged.
  - The pipeline holds the instruction and re-presents it.
- valid_i=0: no HI/LO or FSM side effect from any op; combinational result_o is still driven.

Optional Feature:
- Macro: ALU_MD_FAST_MUL_EN.
- Defined:
  - MULT/MULTU complete in one cycle via a WIDTH x WIDTH multiplier.
  - HI/LO are written at the edge ending cycle t; FSM stays IDLE; busy_o never rises for multiplies.
  - DIV is unchanged.
- Undefined: multiply is iterative as above.

Decomposition:
- Package alu_md_pkg:
  - op encodings (5-bit localparams: ADD, SUB, AND, OR, XOR, NOR, LUI, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO);
  - FSM state encoding IDLE/MUL/DIV;
  - an is_md_op helper function.
- Sub-module md_iter: iterative mul/div engine with its FSM, counter and sign fix-up.
- The top level keeps the combinational ALU, HI/LO and the stall logic.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+1 -> 0x80000000, zero_o=0. SUB 5-5 -> 0, zero_o=1. SLT 0xFFFFFFFF,1 -> 1. SLTU same operands -> 0. SRAV 0x80000000 by a_i=0x24 (uses 4) -> 0xF8000000.
- MULT 0xFFFFFFFE (-2) x 3 at cycle 0:
  - busy_o high cycles 1..32;
  - HI=0xFFFFFFFF, LO=0xFFFFFFFA in cycle 33.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
- MFLO issued at cycle 5 of a running DIV:
  - stall_o=1 through cycle 32;
  - at cycle 33, result_o = new LO.
  - MTHI issued while busy leaves HI unchanged.
- rst asserted at cycle 10 of MULTU:
  - next cycle: busy_o=0, HI=LO=0;
  - a new MULTU 0x10000x0x10000 then yields HI=1, LO=0.
- With ALU_MD_FAST_MUL_EN:
  - MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=1 one cycle later; busy_o stays 0.
  - A following DIV still asserts busy_o for 32 cycles.
